// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Bus widths, reset PC, PC increment, fetch-address exception code and the
// fetch buffer entry type.
package inst_fetch_pkg;

  localparam int unsigned InstAddrW = 32;
  localparam int unsigned InstDataW = 32;

  localparam logic [InstAddrW-1:0] ResetPcDefault = 32'hBFC0_0000;
  localparam logic [InstAddrW-1:0] PcIncr         = 32'd4;

  // Exception code for an instruction-fetch address error (AdEL).
  localparam logic [4:0] ExcCodeFetchAddr = 5'h04;

  typedef struct packed {
    logic [InstAddrW-1:0] pc;
    logic [InstDataW-1:0] inst;
    logic                 excp;
  } fetch_entry_t;

  function automatic logic [InstAddrW-1:0] pc_next(input logic [InstAddrW-1:0] pc);
    return pc + PcIncr;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch stage bus bundle: ROM port, decode handshake and branch redirect.
// master : the fetch stage (drives ROM address/enable and the decode head).
// slave  : the surroundings (ROM, decode, branch unit).
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic                 rom_ce_o;
  logic [InstAddrW-1:0] rom_addr_o;
  logic [InstDataW-1:0] rom_data_i;
  logic                 id_valid_o;
  logic                 id_ready_i;
  logic [InstAddrW-1:0] id_pc_o;
  logic [InstDataW-1:0] id_inst_o;
  logic                 id_excp_o;
  logic                 branch_flag_i;
  logic [InstAddrW-1:0] branch_target_i;

  modport master (
    output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, id_excp_o,
    input  rom_data_i, id_ready_i, branch_flag_i, branch_target_i
  );

  modport slave (
    input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, id_excp_o,
    output rom_data_i, id_ready_i, branch_flag_i, branch_target_i
  );

endinterface

// File: rtl/inst_fetch_fetch_buf.sv
// fetch_buf: Depth-entry FIFO of {pc, inst, excp} between fetch and decode.
// Ports: clk, rst (sync, active-high, zeroes all entries), push/wdata,
// pop, flush (drops all entries, keeps storage), rdata (head entry register),
// count, full, empty.
module fetch_buf
  import inst_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 wdata,
  output fetch_entry_t                 rdata,
  output logic [$clog2(Depth+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // When full, push is only offered together with pop, so the write
      // lands in the slot being vacated this cycle.
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC register, ROM read control and decode handshake.
// Ports: clk, rst (sync, active-high), bus (inst_fetch_if.master: ROM port,
// decode valid/ready with head {pc, inst, excp}, branch redirect).
// Optional feature: INST_FETCH_ALIGN_CHECK_EN turns a misaligned fetch into
// an exception entry and halts fetching until a redirect or reset.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrW-1:0] RESET_PC  = ResetPcDefault,
  parameter int unsigned          BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

  logic [InstAddrW-1:0] pc_q, pc_d;
  logic                 halt;
  logic                 push, pop;
  logic                 buf_full, buf_empty;
  logic [CntW-1:0]      buf_count;
  fetch_entry_t         wr_entry, head;

  // Count is not needed here: full/empty cover every decision.
  logic unused_count;
  assign unused_count = ^buf_count;

  // A redirect discards the head, so it never counts as a pop.
  assign pop  = bus.id_valid_o & bus.id_ready_i & ~bus.branch_flag_i;
  assign push = ~rst & ~halt & ~bus.branch_flag_i & (~buf_full | pop);

`ifdef INST_FETCH_ALIGN_CHECK_EN
  logic misaligned;
  logic halt_q;

  assign misaligned = (pc_q[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else if (bus.branch_flag_i) begin
      halt_q <= 1'b0;
    end else if (push && misaligned) begin
      halt_q <= 1'b1;
    end
  end

  assign halt     = halt_q;
  assign wr_entry = '{pc: pc_q, inst: misaligned ? '0 : bus.rom_data_i, excp: misaligned};
  assign bus.id_excp_o = ~rst & head.excp;
`else
  logic unused_head_excp;
  assign unused_head_excp = head.excp;

  assign halt     = 1'b0;
  assign wr_entry = '{pc: pc_q, inst: bus.rom_data_i, excp: 1'b0};
  assign bus.id_excp_o = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q;
    if (rst) begin
      pc_d = RESET_PC;
    end else if (bus.branch_flag_i) begin
      pc_d = bus.branch_target_i;
    end else if (push) begin
      pc_d = pc_next(pc_q);
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  fetch_buf #(
    .Depth (BUF_DEPTH)
  ) u_fetch_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.branch_flag_i),
    .wdata (wr_entry),
    .rdata (head),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // Outputs show reset values already in the cycle rst is asserted.
  assign bus.rom_ce_o   = push;
  assign bus.rom_addr_o = rst ? RESET_PC : pc_q;
  assign bus.id_valid_o = ~rst & ~buf_empty;
  assign bus.id_pc_o    = rst ? '0 : head.pc;
  assign bus.id_inst_o  = rst ? '0 : head.inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a vector table for reset/run/backpressure,
// hand sequences for redirect, wrap, alignment and mid-stream reset, and a
// queue scoreboard checking every cycle.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] R     = 32'hBFC0_0000;
  localparam int unsigned Depth = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_if bus ();

  inst_fetch #(
    .RESET_PC  (R),
    .BUF_DEPTH (Depth)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  assign bus.rom_data_i = rom_f(bus.rom_addr_o);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // ---------------- scoreboard model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] m_pc   = R;
  logic        m_halt = 1'b0;
  logic        m_pop, m_push;

  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
      m_pc   = R;
      m_halt = 1'b0;
    end else if (bus.branch_flag_i) begin
      sb.delete();
      m_pc   = bus.branch_target_i;
      m_halt = 1'b0;
    end else begin
      m_pop  = (sb.size() > 0) && bus.id_ready_i;
      m_push = !m_halt && ((sb.size() < int'(Depth)) || m_pop);
      if (m_pop) void'(sb.pop_front());
      if (m_push) begin
        e.pc   = m_pc;
        e.inst = rom_f(m_pc);
        e.excp = 1'b0;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        if (m_pc[1:0] != 2'b00) begin
          e.inst = 32'h0;
          e.excp = 1'b1;
          m_halt = 1'b1;
        end
`endif
        sb.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  end

  logic exp_valid, exp_ce;

  always @(negedge clk) begin
    exp_valid = !rst && (sb.size() > 0);
    exp_ce    = !rst && !bus.branch_flag_i && !m_halt &&
                ((sb.size() < int'(Depth)) || (exp_valid && bus.id_ready_i));
    check_bit("sb_ce", bus.rom_ce_o, exp_ce);
    check("sb_addr", bus.rom_addr_o, rst ? R : m_pc);
    check_bit("sb_valid", bus.id_valid_o, exp_valid);
    if (exp_valid) begin
      check("sb_pc", bus.id_pc_o, sb[0].pc);
      check("sb_inst", bus.id_inst_o, sb[0].inst);
      check_bit("sb_excp", bus.id_excp_o, sb[0].excp);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic r, input logic rdy, input logic br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    rst                 = r;
    bus.id_ready_i      = rdy;
    bus.branch_flag_i   = br;
    bus.branch_target_i = tgt;
    @(negedge clk);
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        ce;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl [17];

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    summary();
    $fatal(1);
  end

  initial begin
    bus.id_ready_i      = 1'b1;
    bus.branch_flag_i   = 1'b0;
    bus.branch_target_i = 32'h0;

    // reset 3 cycles then run with ready high
    tbl[0]  = '{rst: 1'b1, rdy: 1'b1, ce: 1'b0, addr: R,       valid: 1'b0, pc: 32'h0};
    tbl[1]  = '{rst: 1'b1, rdy: 1'b1, ce: 1'b0, addr: R,       valid: 1'b0, pc: 32'h0};
    tbl[2]  = '{rst: 1'b1, rdy: 1'b1, ce: 1'b0, addr: R,       valid: 1'b0, pc: 32'h0};
    tbl[3]  = '{rst: 1'b0, rdy: 1'b1, ce: 1'b1, addr: R,       valid: 1'b0, pc: 32'h0};
    tbl[4]  = '{rst: 1'b0, rdy: 1'b1, ce: 1'b1, addr: R + 4,   valid: 1'b1, pc: R};
    tbl[5]  = '{rst: 1'b0, rdy: 1'b1, ce: 1'b1, addr: R + 8,   valid: 1'b1, pc: R + 4};
    // reset again, then backpressure for 5 cycles, then release
    tbl[6]  = '{rst: 1'b1, rdy: 1'b0, ce: 1'b0, addr: R,       valid: 1'b0, pc: 32'h0};
    tbl[7]  = '{rst: 1'b1, rdy: 1'b0, ce: 1'b0, addr: R,       valid: 1'b0, pc: 32'h0};
    tbl[8]  = '{rst: 1'b1, rdy: 1'b0, ce: 1'b0, addr: R,       valid: 1'b0, pc: 32'h0};
    tbl[9]  = '{rst: 1'b0, rdy: 1'b0, ce: 1'b1, addr: R,       valid: 1'b0, pc: 32'h0};
    tbl[10] = '{rst: 1'b0, rdy: 1'b0, ce: 1'b1, addr: R + 4,   valid: 1'b1, pc: R};
    tbl[11] = '{rst: 1'b0, rdy: 1'b0, ce: 1'b0, addr: R + 8,   valid: 1'b1, pc: R};
    tbl[12] = '{rst: 1'b0, rdy: 1'b0, ce: 1'b0, addr: R + 8,   valid: 1'b1, pc: R};
    tbl[13] = '{rst: 1'b0, rdy: 1'b0, ce: 1'b0, addr: R + 8,   valid: 1'b1, pc: R};
    tbl[14] = '{rst: 1'b0, rdy: 1'b1, ce: 1'b1, addr: R + 8,   valid: 1'b1, pc: R};
    tbl[15] = '{rst: 1'b0, rdy: 1'b1, ce: 1'b1, addr: R + 12,  valid: 1'b1, pc: R + 4};
    tbl[16] = '{rst: 1'b0, rdy: 1'b1, ce: 1'b1, addr: R + 16,  valid: 1'b1, pc: R + 8};

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].rst, tbl[i].rdy, 1'b0, 32'h0);
      check_bit($sformatf("vec%0d_ce", i), bus.rom_ce_o, tbl[i].ce);
      check($sformatf("vec%0d_addr", i), bus.rom_addr_o, tbl[i].addr);
      check_bit($sformatf("vec%0d_valid", i), bus.id_valid_o, tbl[i].valid);
      check($sformatf("vec%0d_pc", i), bus.id_pc_o, tbl[i].pc);
    end

    // redirect with a full buffer, decode stalled
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check_bit("br_full_ce", bus.rom_ce_o, 1'b0);
    check("br_full_head", bus.id_pc_o, R + 12);
    cyc(1'b0, 1'b0, 1'b1, 32'h8000_0100);
    check_bit("br_ce_n", bus.rom_ce_o, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check_bit("br_valid_n1", bus.id_valid_o, 1'b0);
    check("br_addr_n1", bus.rom_addr_o, 32'h8000_0100);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check_bit("br_valid_n2", bus.id_valid_o, 1'b1);
    check("br_pc_n2", bus.id_pc_o, 32'h8000_0100);
    check("br_inst_n2", bus.id_inst_o, rom_f(32'h8000_0100));
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("br_pc_n3", bus.id_pc_o, 32'h8000_0104);

    // redirect while the head is being accepted
    cyc(1'b0, 1'b1, 1'b1, 32'h8000_0400);
    check_bit("brp_valid", bus.id_valid_o, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check_bit("brp_valid_n1", bus.id_valid_o, 1'b0);
    check("brp_addr_n1", bus.rom_addr_o, 32'h8000_0400);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("brp_pc_n2", bus.id_pc_o, 32'h8000_0400);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("brp_pc_n3", bus.id_pc_o, 32'h8000_0404);

    // PC wraps modulo 2^32
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("wrap_addr0", bus.rom_addr_o, 32'hFFFF_FFF8);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("wrap_addr1", bus.rom_addr_o, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("wrap_addr2", bus.rom_addr_o, 32'h0000_0000);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("wrap_pc", bus.id_pc_o, 32'h0000_0000);

    // misaligned redirect
    cyc(1'b0, 1'b1, 1'b1, 32'h8000_0102);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check_bit("al_ce", bus.rom_ce_o, 1'b1);
    check("al_addr", bus.rom_addr_o, 32'h8000_0102);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("al_pc", bus.id_pc_o, 32'h8000_0102);
`ifdef INST_FETCH_ALIGN_CHECK_EN
    check_bit("al_excp", bus.id_excp_o, 1'b1);
    check("al_inst", bus.id_inst_o, 32'h0);
    check_bit("al_halt_ce", bus.rom_ce_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      check_bit($sformatf("al_halt_ce%0d", i), bus.rom_ce_o, 1'b0);
      check_bit($sformatf("al_halt_valid%0d", i), bus.id_valid_o, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b1, 32'h8000_0200);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check_bit("al_resume_ce", bus.rom_ce_o, 1'b1);
    check("al_resume_addr", bus.rom_addr_o, 32'h8000_0200);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check("al_resume_pc", bus.id_pc_o, 32'h8000_0200);
    check_bit("al_resume_excp", bus.id_excp_o, 1'b0);
`else
    check_bit("al_excp", bus.id_excp_o, 1'b0);
    check("al_inst", bus.id_inst_o, rom_f(32'h8000_0102));
    check("al_next_addr", bus.rom_addr_o, 32'h8000_0106);
    check_bit("al_next_ce", bus.rom_ce_o, 1'b1);
`endif

    // reset mid-stream with a full buffer and a redirect pending
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check_bit("rs_full_ce", bus.rom_ce_o, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'h8000_0900);
    check_bit("rs_ce", bus.rom_ce_o, 1'b0);
    check("rs_addr", bus.rom_addr_o, R);
    check_bit("rs_valid", bus.id_valid_o, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    check_bit("rs_after_ce", bus.rom_ce_o, 1'b1);
    check("rs_after_addr", bus.rom_addr_o, R);
    check_bit("rs_after_valid", bus.id_valid_o, 1'b0);
    check("rs_after_pc", bus.id_pc_o, 32'h0);
    check("rs_after_inst", bus.id_inst_o, 32'h0);
    check_bit("rs_after_excp", bus.id_excp_o, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check_bit("rs_run_valid", bus.id_valid_o, 1'b1);
    check("rs_run_pc", bus.id_pc_o, R);

    summary();
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage directly upstream of the core's decode logic and directly driving the instruction ROM port. Holds the PC, issues one ROM read per cycle, and captures each {pc, inst} pair in a 2-entry buffer. Decode drains the buffer through a valid/ready handshake. Branch redirects flush the buffer and reload the PC.

## Interface
- RESET_PC, 32'hBFC0_0000, PC loaded on reset.
- BUF_DEPTH, 2, fetch buffer entries; legal values are 2 or 4.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- rom_ce_o  out  1  ROM enable. The ROM is combinational: inst is valid in the same cycle as ce/addr.
- rom_addr_o  out  `INST_ADDR_BUS`  current PC.
- rom_data_i  in  `INST_DATA_BUS`  instruction for rom_addr_o.
- id_valid_o  out  1  buffer head valid.
- id_ready_i  in  1  decode accepts head.
- id_pc_o  out  `INST_ADDR_BUS`  head PC.
- id_inst_o  out  `INST_DATA_BUS`  head instruction.
- id_excp_o  out  1  head is a fetch-address exception.
- branch_flag_i  in  1  redirect request.
- branch_target_i  in  `INST_ADDR_BUS`  redirect PC.

## Operation
- pop = id_valid_o & id_ready_i.
- push = rom_ce_o.
- rom_ce_o = !rst & !halt & !branch_flag_i & (count < BUF_DEPTH | pop).
  - Push is allowed while full if a pop occurs in the same cycle.
- On push:
  - Write {rom_addr_o, rom_data_i, excp=0} at the tail.
  - PC <= PC + 4.
  - Arithmetic is 32-bit modulo. 32'hFFFF_FFFC wraps to 0.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointers wrap modulo BUF_DEPTH.
- Redirect (branch_flag_i=1):
  - At the clock edge: count <= 0, pointers <= 0, PC <= branch_target_i, halt <= 0.
  - The head is discarded even if id_ready_i is high in the same cycle. No pop is counted.
  - Decode must already have accepted any delay-slot instruction before asserting the redirect.
- id_pc_o, id_inst_o and id_excp_o reflect the head entry register contents. When the buffer is empty they show stale data, with id_valid_o=0.
- Reset (rst=1 at an edge):
  - PC=RESET_PC, count=0, halt=0, all entries zeroed.
  - Outputs during and after the reset cycle: rom_ce_o=0, rom_addr_o=RESET_PC, id_valid_o=0, id_pc_o=0, id_inst_o=0, id_excp_o=0.
- Reset asserted mid-operation overrides redirect and push.

## Timing
- Fetch-to-decode latency: 1 cycle. An instruction fetched in cycle N appears at the head in cycle N+1 if the buffer was empty.
- Throughput: 1 instruction/cycle sustained while id_ready_i=1.
- First cycle after rst deasserts: rom_ce_o=1, rom_addr_o=RESET_PC.
- Redirect in cycle N:
  - Cycle N: rom_ce_o=0.
  - Cycle N+1: rom_addr_o=target, id_valid_o=0.
  - Cycle N+2: head = target instruction.
  - Redirect penalty: 2 cycles.
- id_ready_i low: head and outputs are held stable. Fetching continues until the buffer is full, then rom_ce_o=0 and the PC holds.
- Combinational path id_ready_i -> rom_ce_o is accepted; the ROM is combinational.

## Configuration
- INST_FETCH_ALIGN_CHECK_EN defined:
  - If rom_addr_o[1:0] != 0 in a push cycle, the pushed entry is {pc, inst=0, excp=1} and halt <= 1.
  - While halted, rom_ce_o=0.
  - Only a redirect or rst clears halt.
- Macro undefined:
  - No check is made; misaligned addresses go to the ROM unchanged.
  - id_excp_o is tied 0 and the halt register is absent.

## Structure
- Shared include, next to global.vh/rom.vh:
  - RESET_PC default.
  - PC increment constant (4).
  - Exception code for instruction-fetch address error.
  - INST_ADDR_BUS / INST_DATA_BUS reuse.
- Sub-module fetch_buf: BUF_DEPTH-entry FIFO of {pc, inst, excp} with push, pop, flush, count, full and empty.
- inst_fetch contains the PC, halt and control logic.

## Test plan
- Reset then run:
  - rst held 3 cycles, then released, with id_ready_i=1.
  - Required: rom_addr_o is 0xBFC00000, 0xBFC00004, ... on consecutive cycles.
  - Required: id_pc_o trails rom_addr_o by one cycle; id_valid_o is continuous from the second cycle.
- Backpressure:
  - id_ready_i=0 for 5 cycles.
  - Required: exactly 2 pushes, then rom_ce_o=0; PC frozen at RESET_PC+8; head held at 0xBFC00000.
  - On release: in-order delivery with no loss or duplication.
- Redirect:
  - branch_flag_i=1 with target 0x8000_0100 while the buffer holds 2 entries.
  - Required: id_valid_o=0 the next cycle; head = 0x8000_0100 two cycles after the redirect.
  - Required: the discarded entries never appear.
- Redirect with pop:
  - Redirect while id_ready_i=1 and the head is valid.
  - Required: the head is dropped, count=0, no extra pop effect.
- Alignment (macro on):
  - Redirect to 0x8000_0102.
  - Required: one entry with id_excp_o=1 and id_inst_o=0, then rom_ce_o=0 until a redirect to 0x8000_0200 resumes fetching.
- Reset mid-stream:
  - rst=1 with a full buffer and branch_flag_i=1.
  - Required: all outputs reach their reset values next cycle; PC=RESET_PC.
